// File: rtl/uart_param_core.sv
// uart_param_core: parameterised UART transmitter and receiver sharing one clock.
//
// BIT_WIDTH = CLK_FREQ / BAUD_RATE clock cycles per bit (must be >= 8).
// TX and RX are completely independent state machines.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   uart_rx       serial input, asynchronous to clk (synchronised internally)
//   tx_valid      TX word offered
//   tx_data       TX word (DATA_BITS wide)
//   tx_ready      TX idle, accepts a word this cycle
//   uart_tx       registered serial output, idles high
//   tx_busy       TX frame in progress
//   rx_valid      one-cycle pulse, received word valid
//   rx_data       received word, held until the next rx_valid
//   rx_parity_err parity mismatch (0 when PARITY=0), qualified by rx_valid
//   rx_frame_err  stop bit sampled low, qualified by rx_valid
//   rx_busy       RX state machine not idle
module uart_param_core #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,   // 0 none, 1 odd, 2 even
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 uart_tx,
    output logic                 tx_busy,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int unsigned BIT_WIDTH = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W     = $clog2(BIT_WIDTH);
    localparam int unsigned IDX_W     = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_WIDTH - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_WIDTH / 2 - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

    tx_state_e            tx_state_q;
    logic [CNT_W-1:0]     tx_cnt_q;
    logic [IDX_W-1:0]     tx_idx_q;
    logic                 tx_stop_idx_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_par_q;
    logic                 uart_tx_q;

    logic tx_bit_done;
    logic tx_stop_last;

    assign tx_bit_done  = (tx_cnt_q == BIT_LAST);
    assign tx_stop_last = (STOP_BITS == 1) || tx_stop_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q    <= TxIdle;
            tx_cnt_q      <= '0;
            tx_idx_q      <= '0;
            tx_stop_idx_q <= 1'b0;
            tx_shift_q    <= '0;
            tx_par_q      <= 1'b0;
            uart_tx_q     <= 1'b1;
        end else begin
            if (tx_state_q != TxIdle) begin
                tx_cnt_q <= tx_bit_done ? '0 : tx_cnt_q + CNT_W'(1);
            end
            case (tx_state_q)
                TxIdle: begin
                    tx_cnt_q  <= '0;
                    uart_tx_q <= 1'b1;
                    if (tx_valid) begin
                        // Word and its parity are captured here; tx_data may change freely after.
                        tx_state_q <= TxStart;
                        uart_tx_q  <= 1'b0;
                        tx_shift_q <= tx_data;
                        tx_par_q   <= (PARITY == 1) ? ~(^tx_data) : (^tx_data);
                    end
                end
                TxStart: begin
                    if (tx_bit_done) begin
                        tx_state_q <= TxData;
                        uart_tx_q  <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_idx_q   <= '0;
                    end
                end
                TxData: begin
                    if (tx_bit_done) begin
                        if (tx_idx_q == DATA_LAST) begin
                            if (PARITY != 0) begin
                                tx_state_q <= TxParity;
                                uart_tx_q  <= tx_par_q;
                            end else begin
                                tx_state_q    <= TxStop;
                                uart_tx_q     <= 1'b1;
                                tx_stop_idx_q <= 1'b0;
                            end
                        end else begin
                            uart_tx_q  <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_idx_q   <= tx_idx_q + IDX_W'(1);
                        end
                    end
                end
                TxParity: begin
                    if (tx_bit_done) begin
                        tx_state_q    <= TxStop;
                        uart_tx_q     <= 1'b1;
                        tx_stop_idx_q <= 1'b0;
                    end
                end
                TxStop: begin
                    if (tx_bit_done) begin
                        if (tx_stop_last) begin
                            tx_state_q <= TxIdle;
                        end else begin
                            tx_stop_idx_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_state_q <= TxIdle;
                    uart_tx_q  <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx  = uart_tx_q;
    assign tx_ready = (tx_state_q == TxIdle);
    assign tx_busy  = (tx_state_q != TxIdle);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
    } rx_state_e;

    rx_state_e            rx_state_q;
    logic                 rx_sync1_q;
    logic                 rx_sync2_q;
    logic                 rx_prev_q;
    logic [CNT_W-1:0]     rx_cnt_q;
    logic [IDX_W-1:0]     rx_idx_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_par_q;
    logic                 rx_valid_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_perr_q;
    logic                 rx_ferr_q;

    logic rx_line;
    logic rx_fall;
    logic rx_sample;
    logic rx_par_exp;

    assign rx_line    = rx_sync2_q;
    assign rx_fall    = rx_prev_q & ~rx_sync2_q;
    // Start bit is checked at mid-bit; every later sample is one full bit after the last.
    assign rx_sample  = (rx_state_q == RxStart) ? (rx_cnt_q == HALF_LAST) : (rx_cnt_q == BIT_LAST);
    assign rx_par_exp = (PARITY == 1) ? ~(^rx_shift_q) : (^rx_shift_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RxIdle;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_sync1_q <= uart_rx;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_valid_q <= 1'b0;
            if (rx_state_q inside {RxStart, RxData, RxParity, RxStop}) begin
                rx_cnt_q <= rx_sample ? '0 : rx_cnt_q + CNT_W'(1);
            end
            case (rx_state_q)
                RxIdle: begin
                    rx_cnt_q <= '0;
                    if (rx_fall) begin
                        rx_state_q <= RxStart;
                        rx_idx_q   <= '0;
                    end
                end
                RxStart: begin
                    if (rx_sample) begin
                        rx_state_q <= rx_line ? RxIdle : RxData;
                    end
                end
                RxData: begin
                    if (rx_sample) begin
                        // Shift in from the top so the first (LSB) bit ends up at bit 0.
                        rx_shift_q <= {rx_line, rx_shift_q[DATA_BITS-1:1]};
                        rx_idx_q   <= rx_idx_q + IDX_W'(1);
                        if (rx_idx_q == DATA_LAST) begin
                            rx_state_q <= (PARITY != 0) ? RxParity : RxStop;
                        end
                    end
                end
                RxParity: begin
                    if (rx_sample) begin
                        rx_par_q   <= rx_line;
                        rx_state_q <= RxStop;
                    end
                end
                RxStop: begin
                    if (rx_sample) begin
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_shift_q;
                        rx_perr_q  <= (PARITY != 0) && (rx_par_q != rx_par_exp);
                        rx_ferr_q  <= ~rx_line;
                        // A low stop bit (break) must see the line high before re-arming.
                        rx_state_q <= rx_line ? RxIdle : RxWaitHigh;
                    end
                end
                RxWaitHigh: begin
                    if (rx_line) begin
                        rx_state_q <= RxIdle;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_busy       = (rx_state_q != RxIdle);

endmodule

// File: tb/tb_uart_param_core.sv
// Testbench for uart_param_core. Four instances at BIT_WIDTH=16 share one RX line:
//   a: 8N1, b: 8E1, c: 7N2, d: 8O1.
module tb_uart_param_core;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rx_line = 1'b1;

    int total = 0;
    int bad = 0;

    logic       a_tx_valid = 1'b0, b_tx_valid = 1'b0, c_tx_valid = 1'b0, d_tx_valid = 1'b0;
    logic [7:0] a_tx_data = '0, b_tx_data = '0, d_tx_data = '0;
    logic [6:0] c_tx_data = '0;
    logic       a_tx_ready, a_uart_tx, a_tx_busy, a_rx_valid, a_rx_perr, a_rx_ferr, a_rx_busy;
    logic       b_tx_ready, b_uart_tx, b_tx_busy, b_rx_valid, b_rx_perr, b_rx_ferr, b_rx_busy;
    logic       c_tx_ready, c_uart_tx, c_tx_busy, c_rx_valid, c_rx_perr, c_rx_ferr, c_rx_busy;
    logic       d_tx_ready, d_uart_tx, d_tx_busy, d_rx_valid, d_rx_perr, d_rx_ferr, d_rx_busy;
    logic [7:0] a_rx_data, b_rx_data, d_rx_data;
    logic [6:0] c_rx_data;

    // Valid-pulse monitors: count pulses and capture the word/flags of the latest one.
    int a_nv = 0, b_nv = 0, c_nv = 0, d_nv = 0;
    logic [7:0] a_ld = '0, b_ld = '0, d_ld = '0;
    logic [6:0] c_ld = '0;
    logic a_lp = 0, a_lf = 0, b_lp = 0, b_lf = 0, c_lp = 0, c_lf = 0, d_lp = 0, d_lf = 0;

    always #5 clk = ~clk;

    uart_param_core #(.CLK_FREQ(160), .BAUD_RATE(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx_line), .tx_valid(a_tx_valid), .tx_data(a_tx_data),
        .tx_ready(a_tx_ready), .uart_tx(a_uart_tx), .tx_busy(a_tx_busy), .rx_valid(a_rx_valid),
        .rx_data(a_rx_data), .rx_parity_err(a_rx_perr), .rx_frame_err(a_rx_ferr),
        .rx_busy(a_rx_busy)
    );
    uart_param_core #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx_line), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
        .tx_ready(b_tx_ready), .uart_tx(b_uart_tx), .tx_busy(b_tx_busy), .rx_valid(b_rx_valid),
        .rx_data(b_rx_data), .rx_parity_err(b_rx_perr), .rx_frame_err(b_rx_ferr),
        .rx_busy(b_rx_busy)
    );
    uart_param_core #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(7), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx_line), .tx_valid(c_tx_valid), .tx_data(c_tx_data),
        .tx_ready(c_tx_ready), .uart_tx(c_uart_tx), .tx_busy(c_tx_busy), .rx_valid(c_rx_valid),
        .rx_data(c_rx_data), .rx_parity_err(c_rx_perr), .rx_frame_err(c_rx_ferr),
        .rx_busy(c_rx_busy)
    );
    uart_param_core #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx_line), .tx_valid(d_tx_valid), .tx_data(d_tx_data),
        .tx_ready(d_tx_ready), .uart_tx(d_uart_tx), .tx_busy(d_tx_busy), .rx_valid(d_rx_valid),
        .rx_data(d_rx_data), .rx_parity_err(d_rx_perr), .rx_frame_err(d_rx_ferr),
        .rx_busy(d_rx_busy)
    );

    always @(negedge clk) begin
        if (a_rx_valid) begin a_nv <= a_nv + 1; a_ld <= a_rx_data; a_lp <= a_rx_perr; a_lf <= a_rx_ferr; end
        if (b_rx_valid) begin b_nv <= b_nv + 1; b_ld <= b_rx_data; b_lp <= b_rx_perr; b_lf <= b_rx_ferr; end
        if (c_rx_valid) begin c_nv <= c_nv + 1; c_ld <= c_rx_data; c_lp <= c_rx_perr; c_lf <= c_rx_ferr; end
        if (d_rx_valid) begin d_nv <= d_nv + 1; d_ld <= d_rx_data; d_lp <= d_rx_perr; d_lf <= d_rx_ferr; end
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n line bits (bit 0 first), 16 cycles each.
    task automatic send_rx(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_line = bits[i];
            repeat (16) tick();
        end
        rx_line = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        total++;
        if ({a_uart_tx, a_tx_ready, a_tx_busy, a_rx_valid, a_rx_perr, a_rx_ferr, a_rx_busy} !== 7'b1100000) begin
            bad++;
            $display("FAIL reset_a_flags got=%b want=1100000",
                     {a_uart_tx, a_tx_ready, a_tx_busy, a_rx_valid, a_rx_perr, a_rx_ferr, a_rx_busy});
        end
        total++;
        if (a_rx_data !== 8'h00) begin bad++; $display("FAIL reset_a_rx_data got=%h want=00", a_rx_data); end
        total++;
        if ({b_uart_tx, b_tx_ready, b_tx_busy, b_rx_busy, b_rx_data} !== {4'b1100, 8'h00}) begin
            bad++; $display("FAIL reset_b got=%b", {b_uart_tx, b_tx_ready, b_tx_busy, b_rx_busy, b_rx_data});
        end
        total++;
        if ({c_uart_tx, c_tx_ready, c_tx_busy, c_rx_busy, c_rx_data} !== {4'b1100, 7'h00}) begin
            bad++; $display("FAIL reset_c got=%b", {c_uart_tx, c_tx_ready, c_tx_busy, c_rx_busy, c_rx_data});
        end
        total++;
        if ({d_uart_tx, d_tx_ready, d_tx_busy, d_rx_busy, d_rx_data} !== {4'b1100, 8'h00}) begin
            bad++; $display("FAIL reset_d got=%b", {d_uart_tx, d_tx_ready, d_tx_busy, d_rx_busy, d_rx_data});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    // 0xA5 on 8N1: 0,1,0,1,0,0,1,0,1,1; ready again in cycle 161 after acceptance.
    task automatic test_tx_basic();
        logic [9:0] f;
        f = 10'b1101001010;
        a_tx_data  = 8'hA5;
        a_tx_valid = 1'b1;
        tick();
        a_tx_valid = 1'b0;
        a_tx_data  = 8'h00;
        for (int c = 1; c <= 160; c++) begin
            total++;
            if ({a_uart_tx, a_tx_ready, a_tx_busy} !== {f[(c-1)/16], 2'b01}) begin
                bad++;
                $display("FAIL tx_basic cyc=%0d got=%b want=%b", c,
                         {a_uart_tx, a_tx_ready, a_tx_busy}, {f[(c-1)/16], 2'b01});
            end
            tick();
        end
        total++;
        if ({a_uart_tx, a_tx_ready, a_tx_busy} !== 3'b110) begin
            bad++; $display("FAIL tx_basic_ready got=%b want=110", {a_uart_tx, a_tx_ready, a_tx_busy});
        end
        repeat (4) tick();
    endtask

    // 0x3C: even parity bit 0 (dut_b), odd parity bit 1 (dut_d).
    task automatic test_tx_parity();
        logic [10:0] fb;
        logic [10:0] fd;
        fb = 11'b10001111000;
        fd = 11'b11001111000;
        b_tx_data = 8'h3C; d_tx_data = 8'h3C;
        b_tx_valid = 1'b1; d_tx_valid = 1'b1;
        tick();
        b_tx_valid = 1'b0; d_tx_valid = 1'b0;
        for (int c = 1; c <= 176; c++) begin
            total++;
            if ({b_uart_tx, b_tx_busy} !== {fb[(c-1)/16], 1'b1}) begin
                bad++; $display("FAIL tx_even cyc=%0d got=%b want=%b", c, {b_uart_tx, b_tx_busy}, {fb[(c-1)/16], 1'b1});
            end
            total++;
            if ({d_uart_tx, d_tx_busy} !== {fd[(c-1)/16], 1'b1}) begin
                bad++; $display("FAIL tx_odd cyc=%0d got=%b want=%b", c, {d_uart_tx, d_tx_busy}, {fd[(c-1)/16], 1'b1});
            end
            tick();
        end
        total++;
        if ({b_tx_ready, d_tx_ready, b_uart_tx, d_uart_tx} !== 4'b1111) begin
            bad++; $display("FAIL tx_parity_ready got=%b want=1111", {b_tx_ready, d_tx_ready, b_uart_tx, d_uart_tx});
        end
        repeat (4) tick();
    endtask

    // 7N2 with tx_valid held: two frames of 0x41 with exactly one idle-high cycle between.
    task automatic test_back_to_back();
        logic [9:0] f;
        logic       e;
        logic       rdy;
        f = 10'b1110000010;
        c_tx_data  = 7'h41;
        c_tx_valid = 1'b1;
        tick();
        for (int c = 1; c <= 322; c++) begin
            if (c <= 160) begin e = f[(c-1)/16]; rdy = 1'b0; end
            else if (c == 161) begin e = 1'b1; rdy = 1'b1; end
            else if (c <= 321) begin e = f[(c-162)/16]; rdy = 1'b0; end
            else begin e = 1'b1; rdy = 1'b1; end
            total++;
            if ({c_uart_tx, c_tx_ready, c_tx_busy} !== {e, rdy, ~rdy}) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%b want=%b", c,
                         {c_uart_tx, c_tx_ready, c_tx_busy}, {e, rdy, ~rdy});
            end
            if (c == 200) c_tx_valid = 1'b0;
            tick();
        end
        repeat (4) tick();
    endtask

    // 0x3C with parity bit 1 on the shared line; each configuration decodes it differently.
    task automatic test_rx_parity();
        int a0, b0, c0, d0;
        a0 = a_nv; b0 = b_nv; c0 = c_nv; d0 = d_nv;
        send_rx(16'b0000011001111000, 11);
        repeat (40) tick();
        total++;
        if ({b_nv - b0, b_ld, b_lp, b_lf} !== {32'd1, 8'h3C, 2'b10}) begin
            bad++; $display("FAIL rx_even n=%0d data=%h perr=%b ferr=%b want n=1 3C 1 0", b_nv - b0, b_ld, b_lp, b_lf);
        end
        total++;
        if ({d_nv - d0, d_ld, d_lp, d_lf} !== {32'd1, 8'h3C, 2'b00}) begin
            bad++; $display("FAIL rx_odd n=%0d data=%h perr=%b ferr=%b want n=1 3C 0 0", d_nv - d0, d_ld, d_lp, d_lf);
        end
        total++;
        if ({a_nv - a0, a_ld, a_lp, a_lf} !== {32'd1, 8'h3C, 2'b00}) begin
            bad++; $display("FAIL rx_none n=%0d data=%h perr=%b ferr=%b want n=1 3C 0 0", a_nv - a0, a_ld, a_lp, a_lf);
        end
        total++;
        if ({c_nv - c0, c_ld, c_lp, c_lf} !== {32'd1, 7'h3C, 2'b01}) begin
            bad++; $display("FAIL rx_7bit n=%0d data=%h perr=%b ferr=%b want n=1 3C 0 1", c_nv - c0, c_ld, c_lp, c_lf);
        end
        total++;
        if ({b_rx_data, b_rx_perr, b_rx_busy} !== {8'h3C, 2'b10}) begin
            bad++; $display("FAIL rx_hold got=%h/%b/%b want 3C/1/0", b_rx_data, b_rx_perr, b_rx_busy);
        end
    endtask

    task automatic test_rx_false_start();
        int   a0;
        logic seen;
        a0 = a_nv;
        seen = 1'b0;
        rx_line = 1'b0;
        repeat (5) tick();
        rx_line = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (a_rx_busy) seen = 1'b1;
            tick();
        end
        total++;
        if ({seen, a_rx_busy} !== 2'b10) begin
            bad++; $display("FAIL false_start seen_busy=%b busy=%b want 1 0", seen, a_rx_busy);
        end
        total++;
        if (a_nv !== a0) begin bad++; $display("FAIL false_start_valid got=%0d want=%0d", a_nv, a0); end
    endtask

    // Line low for 30 bit times: one word 0x00 with frame error, then silence until a real start.
    task automatic test_rx_break();
        int a0;
        a0 = a_nv;
        rx_line = 1'b0;
        repeat (480) tick();
        total++;
        if ({a_nv - a0, a_ld, a_lp, a_lf, a_rx_busy} !== {32'd1, 8'h00, 3'b011}) begin
            bad++; $display("FAIL break n=%0d data=%h perr=%b ferr=%b busy=%b want n=1 00 0 1 1",
                            a_nv - a0, a_ld, a_lp, a_lf, a_rx_busy);
        end
        rx_line = 1'b1;
        repeat (32) tick();
        total++;
        if ({a_nv - a0, a_rx_busy} !== {32'd1, 1'b0}) begin
            bad++; $display("FAIL break_release n=%0d busy=%b want n=1 busy=0", a_nv - a0, a_rx_busy);
        end
        send_rx(16'b0000001010110100, 10);
        repeat (32) tick();
        total++;
        if ({a_nv - a0, a_ld, a_lp, a_lf} !== {32'd2, 8'h5A, 2'b00}) begin
            bad++; $display("FAIL break_next n=%0d data=%h perr=%b ferr=%b want n=2 5A 0 0", a_nv - a0, a_ld, a_lp, a_lf);
        end
    endtask

    // Reset mid-TX/mid-RX, then a TX frame and an RX frame running at the same time.
    task automatic test_reset_concurrent();
        int         a0;
        logic [9:0] tf;
        logic [9:0] rf;
        tf = 10'b1001111000;
        rf = 10'b1100101100;
        a0 = a_nv;
        a_tx_data  = 8'hA5;
        a_tx_valid = 1'b1;
        rx_line    = 1'b0;
        tick();
        a_tx_valid = 1'b0;
        repeat (50) tick();
        total++;
        if ({a_tx_busy, a_rx_busy} !== 2'b11) begin
            bad++; $display("FAIL pre_reset_busy got=%b want=11", {a_tx_busy, a_rx_busy});
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({a_uart_tx, a_tx_ready, a_tx_busy, a_rx_busy, a_rx_valid} !== 5'b11000) begin
            bad++; $display("FAIL async_reset got=%b want=11000", {a_uart_tx, a_tx_ready, a_tx_busy, a_rx_busy, a_rx_valid});
        end
        rx_line = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (200) tick();
        total++;
        if ({a_nv - a0, a_rx_data, a_uart_tx, a_tx_ready} !== {32'd0, 8'h00, 2'b11}) begin
            bad++; $display("FAIL post_reset n=%0d data=%h tx=%b rdy=%b want n=0 00 1 1",
                            a_nv - a0, a_rx_data, a_uart_tx, a_tx_ready);
        end
        a_tx_data  = 8'h3C;
        a_tx_valid = 1'b1;
        rx_line    = rf[0];
        for (int c = 1; c <= 176; c++) begin
            tick();
            if (c == 1) a_tx_valid = 1'b0;
            rx_line = (c < 160) ? rf[c/16] : 1'b1;
            if (c <= 160) begin
                total++;
                if (a_uart_tx !== tf[(c-1)/16]) begin
                    bad++; $display("FAIL concurrent_tx cyc=%0d got=%b want=%b", c, a_uart_tx, tf[(c-1)/16]);
                end
            end
        end
        repeat (32) tick();
        total++;
        if ({a_nv - a0, a_ld, a_lp, a_lf, a_tx_ready} !== {32'd1, 8'h96, 3'b001}) begin
            bad++; $display("FAIL concurrent_rx n=%0d data=%h perr=%b ferr=%b rdy=%b want n=1 96 0 0 1",
                            a_nv - a0, a_ld, a_lp, a_lf, a_tx_ready);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_parity();
        test_back_to_back();
        test_rx_parity();
        test_rx_false_start();
        test_rx_break();
        test_reset_concurrent();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_param_core.md
UART_PARAM_CORE -- requirements
Module: uart_param_core

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, meaning clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, meaning line bit rate; BIT_WIDTH = CLK_FREQ/BAUD_RATE (integer, truncated), legal range >= 8.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal 5..9.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning TX stop bits, legal 1 or 2.
REQ-006 Ports SHALL be:
 clk  in  1  single clock, rising edge
 rst_n  in  1  reset, asynchronous, active-low
 uart_rx  in  1  serial input, asynchronous to clk
 tx_valid  in  1  TX word offered
 tx_data  in  DATA_BITS  TX word
 tx_ready  out  1  TX accepts a word this cycle
 uart_tx  out  1  serial output, registered
 tx_busy  out  1  frame in progress on uart_tx
 rx_valid  out  1  one-cycle pulse, received word valid
 rx_data  out  DATA_BITS  received word
 rx_parity_err  out  1  parity mismatch, qualified by rx_valid
 rx_frame_err  out  1  stop bit sampled low, qualified by rx_valid
 rx_busy  out  1  RX FSM not IDLE

Function
REQ-007 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-008 tx_ready SHALL be 1 only in IDLE; a word SHALL be accepted on a cycle with tx_valid & tx_ready, tx_data latched that cycle.
REQ-009 uart_tx SHALL go low on the cycle after acceptance; every bit SHALL last exactly BIT_WIDTH cycles.
REQ-010 Frame order SHALL be start 0, data LSB first, parity bit (odd: XOR of data inverted; even: XOR of data), STOP_BITS high bits.
REQ-011 After the last stop bit period the FSM SHALL return to IDLE (tx_ready=1) for at least one cycle; uart_tx SHALL stay 1 in IDLE, so back-to-back words have a 1-cycle gap maximum beyond the stop bits.
REQ-012 tx_data changes after acceptance SHALL not affect the frame in flight; tx_busy SHALL equal (state != IDLE).
REQ-013 uart_rx SHALL pass a 2-FF synchroniser (reset value 1) before any use.
REQ-014 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-015 In IDLE a synchronised 1->0 transition SHALL enter START and zero the bit counter.
REQ-016 In START the line SHALL be sampled at BIT_WIDTH/2 cycles; sample 1 = false start, return to IDLE, no rx_valid.
REQ-017 Data, parity and the first stop bit SHALL each be sampled BIT_WIDTH cycles after the previous sample; data assembled LSB first.
REQ-018 At the stop sample: rx_valid SHALL pulse 1 cycle the next cycle with rx_data, rx_parity_err (0 when PARITY=0) and rx_frame_err (stop sample==0) updated in that same cycle.
REQ-019 rx_data and both error flags SHALL hold until the next rx_valid.
REQ-020 Stop sample 1 SHALL return to IDLE immediately (only one stop bit checked); stop sample 0 SHALL enter WAIT_HIGH, which returns to IDLE only after a synchronised 1 is seen (break does not retrigger).
REQ-021 TX and RX SHALL operate fully independently, including simultaneous activity.

Reset
REQ-022 rst_n low SHALL asynchronously force both FSMs to IDLE, counters 0, uart_tx=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0, rx_busy=0, synchroniser=1.
REQ-023 Reset mid-frame SHALL abort the frame without rx_valid; uart_tx SHALL be 1 during and after reset until the next acceptance.

Verification (CLK_FREQ=160, BAUD_RATE=10 -> BIT_WIDTH=16)
REQ-024 Defaults, tx_data=0xA5 accepted -> uart_tx: 0,1,0,1,0,0,1,0,1,1, each 16 cycles; tx_ready high again 161 cycles after acceptance.
REQ-025 PARITY=2, uart_rx frame of 0x3C with parity bit 1 -> rx_valid pulse, rx_data=0x3C, rx_parity_err=1, rx_frame_err=0.
REQ-026 uart_rx low for 5 cycles then high -> no rx_valid, rx_busy back to 0 after mid-bit check.
REQ-027 uart_rx held low 30 bit times -> one rx_valid with rx_data=0x00, rx_frame_err=1; no further rx_valid until line high then a new start.
REQ-028 DATA_BITS=7, STOP_BITS=2, tx_valid held high with 0x41 -> two frames, each 10 bits low-to-high correct, ≤1 idle cycle between them beyond 2 stop bits.
REQ-029 rst_n pulsed low mid-TX and mid-RX -> uart_tx=1 immediately, no rx_valid, next frames correct.
